// File: rtl/updown_counter_bounded.sv
// rtl/updown_counter_bounded.sv - bounded up/down counter with wrap/saturate mode, carry/borrow pulses and sticky error flags (optional parallel load: UDC_LOAD_EN)
module updown_counter_bounded #(
    parameter int BUSWIDTH = 10,
    parameter int MAXCOUNT = 1023,
    parameter bit WRAP     = 1'b0
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                En,
    input  logic                D,
    input  logic                ErrClr,
`ifdef UDC_LOAD_EN
    input  logic                Load,
    input  logic [BUSWIDTH-1:0] LoadVal,
`endif
    output logic [BUSWIDTH-1:0] Out,
    output logic                AtMax,
    output logic                AtMin,
    output logic                Cout,
    output logic                Bout,
    output logic                OvfErr,
    output logic                UnfErr
);

    localparam logic [BUSWIDTH-1:0] MAX_VAL = BUSWIDTH'(MAXCOUNT);
    localparam logic [BUSWIDTH-1:0] ONE     = BUSWIDTH'(1);

    logic [BUSWIDTH-1:0] out_q, out_d;
    logic                cout_q, cout_d;
    logic                bout_q, bout_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                at_max, at_min;

    assign at_max = (out_q == MAX_VAL);
    assign at_min = (out_q == '0);

    // Next-state: load beats a count step; a set event beats ErrClr on the sticky flags
    always_comb begin
        out_d  = out_q;
        cout_d = 1'b0;
        bout_d = 1'b0;
        ovf_d  = ovf_q & ~ErrClr;
        unf_d  = unf_q & ~ErrClr;
`ifdef UDC_LOAD_EN
        if (Load) begin
            // Loads above the terminal count are clamped so the range invariant holds
            out_d = (LoadVal > MAX_VAL) ? MAX_VAL : LoadVal;
        end else
`endif
        if (En) begin
            if (D) begin
                if (at_max) begin
                    cout_d = 1'b1;
                    ovf_d  = 1'b1;
                    if (WRAP) begin
                        out_d = '0;
                    end
                end else begin
                    out_d = out_q + ONE;
                end
            end else begin
                if (at_min) begin
                    bout_d = 1'b1;
                    unf_d  = 1'b1;
                    if (WRAP) begin
                        out_d = MAX_VAL;
                    end
                end else begin
                    out_d = out_q - ONE;
                end
            end
        end
    end

    // State register with synchronous reset; reset discards any same-cycle step
    always_ff @(posedge Clk) begin
        if (Rst) begin
            out_q  <= '0;
            cout_q <= 1'b0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            out_q  <= out_d;
            cout_q <= cout_d;
            bout_q <= bout_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    assign Out    = out_q;
    assign AtMax  = at_max;
    assign AtMin  = at_min;
    assign Cout   = cout_q;
    assign Bout   = bout_q;
    assign OvfErr = ovf_q;
    assign UnfErr = unf_q;

endmodule

// File: tb/tb_updown_counter_bounded.sv
// tb/tb_updown_counter_bounded.sv - scoreboard bench driving a saturating and a wrapping counter side by side
module tb_updown_counter_bounded;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       d = 1'b0;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] lv = 4'd0;

    logic [3:0] out0, out1;
    logic       amax0, amin0, cout0, bout0, ovf0, unf0;
    logic       amax1, amin1, cout1, bout1, ovf1, unf1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       rst, en, d, clr, load;
        logic [3:0] lv;
        logic [3:0] o0;
        logic       c0, b0, v0, u0;
        logic [3:0] o1;
        logic       c1, b1, v1, u1;
    } vec_t;

    typedef struct packed {
        logic [3:0] o0;
        logic       c0, b0, v0, u0;
        logic [3:0] o1;
        logic       c1, b1, v1, u1;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    always #5 clk = ~clk;

    updown_counter_bounded #(.BUSWIDTH(4), .MAXCOUNT(9), .WRAP(1'b0)) dut_sat (
        .Clk(clk), .Rst(rst), .En(en), .D(d), .ErrClr(clr),
`ifdef UDC_LOAD_EN
        .Load(load), .LoadVal(lv),
`endif
        .Out(out0), .AtMax(amax0), .AtMin(amin0), .Cout(cout0), .Bout(bout0),
        .OvfErr(ovf0), .UnfErr(unf0)
    );

    updown_counter_bounded #(.BUSWIDTH(4), .MAXCOUNT(9), .WRAP(1'b1)) dut_wrap (
        .Clk(clk), .Rst(rst), .En(en), .D(d), .ErrClr(clr),
`ifdef UDC_LOAD_EN
        .Load(load), .LoadVal(lv),
`endif
        .Out(out1), .AtMax(amax1), .AtMin(amin1), .Cout(cout1), .Bout(bout1),
        .OvfErr(ovf1), .UnfErr(unf1)
    );

    task automatic chk(input string name, input int step, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s step %0d: got %0d expected %0d", name, step, act, req);
        end
    endtask

    // args: rst en d clr load lv | sat: out cout bout ovf unf | wrap: out cout bout ovf unf
    task automatic add(input logic r, e, dd, c, l, input logic [3:0] v,
                       input logic [3:0] o0, input logic c0, b0, v0, u0,
                       input logic [3:0] o1, input logic c1, b1, v1, u1);
        vec_t t;
        t = '{r, e, dd, c, l, v, o0, c0, b0, v0, u0, o1, c1, b1, v1, u1};
        vecs.push_back(t);
    endtask

    // Monitor: every edge the counters present a new state; compare it to the oldest expectation
    initial begin
        int step;
        exp_t x;
        step = 0;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                chk("sat_out",   step, int'(out0),  int'(x.o0));
                chk("sat_cout",  step, int'(cout0), int'(x.c0));
                chk("sat_bout",  step, int'(bout0), int'(x.b0));
                chk("sat_ovf",   step, int'(ovf0),  int'(x.v0));
                chk("sat_unf",   step, int'(unf0),  int'(x.u0));
                chk("sat_atmax", step, int'(amax0), int'(x.o0 == 4'd9));
                chk("sat_atmin", step, int'(amin0), int'(x.o0 == 4'd0));
                chk("wrap_out",  step, int'(out1),  int'(x.o1));
                chk("wrap_cout", step, int'(cout1), int'(x.c1));
                chk("wrap_bout", step, int'(bout1), int'(x.b1));
                chk("wrap_ovf",  step, int'(ovf1),  int'(x.v1));
                chk("wrap_unf",  step, int'(unf1),  int'(x.u1));
                chk("wrap_atmax",step, int'(amax1), int'(x.o1 == 4'd9));
                chk("wrap_atmin",step, int'(amin1), int'(x.o1 == 4'd0));
                chk("no_cout_bout_both", step, int'(cout1 & bout1), 0);
                step++;
            end
        end
    end

    // Stimulus: drive each vector at the falling edge and queue its expected result
    initial begin
        exp_t x;
        // reset state
        add(1,0,0,0,0,4'd0,  4'd0,0,0,0,0,  4'd0,0,0,0,0);
        // count up 1..9, no carry
        for (int i = 1; i <= 9; i++)
            add(0,1,1,0,0,4'd0,  4'(i),0,0,0,0,  4'(i),0,0,0,0);
        // up at MAX: saturate vs wrap, carry pulse and overflow
        add(0,1,1,0,0,4'd0,  4'd9,1,0,1,0,  4'd0,1,0,1,0);
        // idle: pulse drops, flag sticks
        add(0,0,0,0,0,4'd0,  4'd9,0,0,1,0,  4'd0,0,0,1,0);
        // ErrClr clears overflow
        add(0,0,0,1,0,4'd0,  4'd9,0,0,0,0,  4'd0,0,0,0,0);
        // down: sat 9->8, wrap 0->9 with borrow
        add(0,1,0,0,0,4'd0,  4'd8,0,0,0,0,  4'd9,0,1,0,1);
        // up: sat 8->9, wrap 9->0 with carry
        add(0,1,1,0,0,4'd0,  4'd9,0,0,0,0,  4'd0,1,0,1,1);
        // clear both flags
        add(0,0,0,1,0,4'd0,  4'd9,0,0,0,0,  4'd0,0,0,0,0);
        // down with ErrClr: wrap underflows, set wins
        add(0,1,0,1,0,4'd0,  4'd8,0,0,0,0,  4'd9,0,1,0,1);
        // reset, count up to 5
        add(1,0,0,0,0,4'd0,  4'd0,0,0,0,0,  4'd0,0,0,0,0);
        for (int i = 1; i <= 5; i++)
            add(0,1,1,0,0,4'd0,  4'(i),0,0,0,0,  4'(i),0,0,0,0);
        // reset while counting up discards the step
        add(1,1,1,0,0,4'd0,  4'd0,0,0,0,0,  4'd0,0,0,0,0);
        // down at 0: sat holds, wrap goes to 9; both borrow
        add(0,1,0,0,0,4'd0,  4'd0,0,1,0,1,  4'd9,0,1,0,1);
        // down again: sat borrows again, wrap 9->8
        add(0,1,0,0,0,4'd0,  4'd0,0,1,0,1,  4'd8,0,0,0,1);
        // idle
        add(0,0,0,0,0,4'd0,  4'd0,0,0,0,1,  4'd8,0,0,0,1);
`ifdef UDC_LOAD_EN
        // load 14 clamps to 9, overrides En up, no carry, flags unchanged
        add(0,1,1,0,1,4'd14, 4'd9,0,0,0,1,  4'd9,0,0,0,1);
        // load 3
        add(0,0,0,0,1,4'd3,  4'd3,0,0,0,1,  4'd3,0,0,0,1);
        // load 9 while En up at 3: load wins
        add(0,1,1,0,1,4'd9,  4'd9,0,0,0,1,  4'd9,0,0,0,1);
        // load 0 while En down at 9
        add(0,1,0,0,1,4'd0,  4'd0,0,0,0,1,  4'd0,0,0,0,1);
`endif

        foreach (vecs[i]) begin
            @(negedge clk);
            rst  = vecs[i].rst;
            en   = vecs[i].en;
            d    = vecs[i].d;
            clr  = vecs[i].clr;
            load = vecs[i].load;
            lv   = vecs[i].lv;
            x = '{vecs[i].o0, vecs[i].c0, vecs[i].b0, vecs[i].v0, vecs[i].u0,
                  vecs[i].o1, vecs[i].c1, vecs[i].b1, vecs[i].v1, vecs[i].u1};
            exp_q.push_back(x);
        end
        @(negedge clk);
        rst = 1'b0; en = 1'b0; d = 1'b0; clr = 1'b0; load = 1'b0; lv = 4'd0;

        for (int i = 0; i < 10 && exp_q.size() != 0; i++)
            @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
